game_timer: RTL and testbench
=============================

GAME_TIMER -- requirements
Module: game_timer

Interface
REQ-001 SHALL have parameter CLOCK_FREQUENCY, default 50000000, giving clock cycles per one-second tick; legal values are >= 2.
REQ-002 SHALL have parameter START_TENS, default 6, giving the BCD tens digit of the start time; legal values are 0..9.
REQ-003 SHALL have parameter START_ONES, default 0, giving the BCD ones digit of the start time; legal values are 0..9.
REQ-004 SHALL have port ClockIn, input, 1 bit: system clock; all logic on its rising edge.
REQ-005 SHALL have port Reset, input, 1 bit: reset, synchronous, active-high.
REQ-006 SHALL have port Start, input, 1 bit: level-sampled start/restart request.
REQ-007 SHALL have port Pause, input, 1 bit: level-sampled pause request.
REQ-008 SHALL have port OnesValue, output, 4 bits: BCD ones digit of the remaining seconds, feeding the hex decoder for HEX0.
REQ-009 SHALL have port TensValue, output, 4 bits: BCD tens digit of the remaining seconds, feeding the hex decoder for HEX1.
REQ-010 SHALL have port Running, output, 1 bit: high while state is RUNNING.
REQ-011 SHALL have port Expired, output, 1 bit: high while state is EXPIRED.
REQ-012 SHALL have port TimeUp, output, 1 bit: one-cycle pulse when the count reaches 00.

Function
REQ-013 SHALL implement FSM states IDLE, RUNNING, PAUSED and EXPIRED; all outputs registered.
REQ-014 SHALL hold the digits at START_TENS:START_ONES in IDLE; Start=1 moves to RUNNING and loads the prescaler with CLOCK_FREQUENCY-1.
REQ-015 SHALL decrement the prescaler by 1 each RUNNING cycle; at 0 it issues one tick, reloads CLOCK_FREQUENCY-1 and decrements the BCD count.
REQ-016 SHALL apply BCD decrement as: ones>0 -> ones-1; ones=0 and tens>0 -> ones=9, tens-1; the digits never leave 0..9.
REQ-017 SHALL, on the edge where a tick writes 00, enter EXPIRED with TimeUp=1 for exactly that following cycle; the digits hold 00.
REQ-018 SHALL move RUNNING with Pause=1 to PAUSED; the prescaler and digits freeze and Running=0.
REQ-019 SHALL move PAUSED with Pause=0 to RUNNING, resuming from the frozen prescaler value; no reload occurs.
REQ-020 SHALL let Pause win when Pause and a tick coincide in RUNNING: no decrement; the prescaler stays at 0 and the tick fires on the first resumed cycle.
REQ-021 SHALL ignore Start in RUNNING and PAUSED: no reload and no prescaler change.
REQ-022 SHALL, on Start in EXPIRED, reload the start digits and the prescaler and move to RUNNING; Expired falls on the same edge.
REQ-023 SHALL ignore Pause in IDLE and EXPIRED; Start and Pause together in IDLE goes to RUNNING.
REQ-024 SHALL, when START_TENS=START_ONES=0, move from IDLE on Start directly to EXPIRED with a TimeUp pulse.
REQ-025 SHALL size the prescaler as ceil(log2(CLOCK_FREQUENCY)) bits.

Reset
REQ-026 SHALL, on Reset=1 at a clock edge in any state including mid-count: state=IDLE, OnesValue=START_ONES, TensValue=START_TENS, Running=0, Expired=0, TimeUp=0, prescaler=CLOCK_FREQUENCY-1.
REQ-027 SHALL give Reset priority over Start, Pause and tick.

Structure
REQ-028 SHALL place in shared package game_pkg: the state encoding (IDLE=00, RUNNING=01, PAUSED=10, EXPIRED=11) and the BCD constants BCD_ZERO=0 and BCD_NINE=9.
REQ-029 SHALL implement the prescaler as one sub-module, second_tick_gen, with inputs load, hold and enable and output tick; the FSM and BCD logic stay in game_timer.

Verification (CLOCK_FREQUENCY=4, START=60 unless stated)
REQ-030 SHALL cover: Reset, one-cycle Start -> 59 four cycles after entering RUNNING; 00 after 240 cycles; TimeUp high exactly 1 cycle; Expired=1 thereafter.
REQ-031 SHALL cover: tens borrow, count 50 plus one tick -> TensValue=4, OnesValue=9 on the same edge.
REQ-032 SHALL cover: Pause held 10 cycles at 45 with prescaler=2 -> digits stay 45, Running=0; release -> 44 after exactly 3 more cycles.
REQ-033 SHALL cover: Pause asserted in the cycle the prescaler=0 -> no decrement while paused; decrement on the first cycle after release.
REQ-034 SHALL cover: Reset at 23 mid-run -> next cycle 60, IDLE, all flags 0; Start while RUNNING -> no reload, tick timing unchanged.
REQ-035 SHALL cover: Start in EXPIRED -> 60, Running=1, Expired=0 on the next edge; START_TENS=START_ONES=0 with Start -> Expired=1 and a TimeUp pulse.

Source files
------------

// File: rtl/game_pkg.sv
// Shared encodings and helpers for the countdown game timer.
package game_pkg;

   localparam int unsigned STATE_W = 2;
   localparam int unsigned BCD_W   = 4;

   localparam logic [STATE_W-1:0] ST_IDLE    = 2'b00;
   localparam logic [STATE_W-1:0] ST_RUNNING = 2'b01;
   localparam logic [STATE_W-1:0] ST_PAUSED  = 2'b10;
   localparam logic [STATE_W-1:0] ST_EXPIRED = 2'b11;

   localparam logic [BCD_W-1:0] BCD_ZERO = 4'd0;
   localparam logic [BCD_W-1:0] BCD_NINE = 4'd9;

   typedef struct packed {
      logic [BCD_W-1:0] tens;
      logic [BCD_W-1:0] ones;
   } bcd_t;

   // Two-digit BCD decrement that saturates at 00.
   function automatic bcd_t bcd_dec(input bcd_t v);
      bcd_t r;
      r = v;
      if (v.ones != BCD_ZERO) begin
         r.ones = v.ones - 4'd1;
      end else if (v.tens != BCD_ZERO) begin
         r.ones = BCD_NINE;
         r.tens = v.tens - 4'd1;
      end
      return r;
   endfunction

endpackage

// File: rtl/second_tick_gen.sv
// Prescaler issuing one tick every CLOCK_FREQUENCY enabled cycles; hold freezes it.
module second_tick_gen #(
   parameter int unsigned CLOCK_FREQUENCY = 50000000
) (
   input  logic ClockIn,
   input  logic Reset,
   input  logic load,
   input  logic hold,
   input  logic enable,
   output logic tick
);

   localparam int unsigned W = (CLOCK_FREQUENCY > 1) ? $clog2(CLOCK_FREQUENCY) : 1;
   localparam logic [W-1:0] RELOAD = W'(CLOCK_FREQUENCY - 1);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   // Tick only when actually counting, so a held prescaler parked at 0 fires on resume.
   assign tick = enable && !hold && (count_q == '0);

   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = RELOAD;
      end else if (enable && !hold) begin
         count_d = (count_q == '0) ? RELOAD : count_q - W'(1);
      end
   end

   always_ff @(posedge ClockIn) begin
      if (Reset) begin
         count_q <= RELOAD;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/game_timer.sv
// Two-digit BCD countdown timer with start/pause control and expiry pulse.
module game_timer
   import game_pkg::*;
#(
   parameter int unsigned CLOCK_FREQUENCY = 50000000,
   parameter int unsigned START_TENS      = 6,
   parameter int unsigned START_ONES      = 0
) (
   input  logic             ClockIn,
   input  logic             Reset,
   input  logic             Start,
   input  logic             Pause,
   output logic [BCD_W-1:0] OnesValue,
   output logic [BCD_W-1:0] TensValue,
   output logic             Running,
   output logic             Expired,
   output logic             TimeUp
);

   localparam logic [BCD_W-1:0] START_T = BCD_W'(START_TENS);
   localparam logic [BCD_W-1:0] START_O = BCD_W'(START_ONES);
   localparam bit START_IS_ZERO = (START_TENS == 0) && (START_ONES == 0);

   logic [STATE_W-1:0] state_q, state_d;
   bcd_t               digits_q, digits_d;
   bcd_t               dec_c;
   logic               running_q, running_d;
   logic               expired_q, expired_d;
   logic               time_up_q, time_up_d;
   logic               load_c;
   logic               enable_c;
   logic               tick_c;

   second_tick_gen #(
      .CLOCK_FREQUENCY(CLOCK_FREQUENCY)
   ) u_tick (
      .ClockIn(ClockIn),
      .Reset  (Reset),
      .load   (load_c),
      .hold   (Pause),
      .enable (enable_c),
      .tick   (tick_c)
   );

   always_comb begin
      state_d   = state_q;
      digits_d  = digits_q;
      time_up_d = 1'b0;
      load_c    = 1'b0;
      enable_c  = (state_q == ST_RUNNING);
      dec_c     = bcd_dec(digits_q);
      case (state_q)
         ST_IDLE, ST_EXPIRED: begin
            if (Start) begin
               load_c        = 1'b1;
               digits_d.tens = START_T;
               digits_d.ones = START_O;
               state_d       = START_IS_ZERO ? ST_EXPIRED : ST_RUNNING;
               time_up_d     = START_IS_ZERO;
            end
         end
         ST_RUNNING: begin
            // tick already excludes Pause, so a coinciding pause suppresses the decrement.
            if (Pause) begin
               state_d = ST_PAUSED;
            end else if (tick_c) begin
               digits_d = dec_c;
               if (dec_c.tens == BCD_ZERO && dec_c.ones == BCD_ZERO) begin
                  state_d   = ST_EXPIRED;
                  time_up_d = 1'b1;
               end
            end
         end
         ST_PAUSED: begin
            if (!Pause) begin
               state_d = ST_RUNNING;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      running_d = (state_d == ST_RUNNING);
      expired_d = (state_d == ST_EXPIRED);
   end

   always_ff @(posedge ClockIn) begin
      if (Reset) begin
         state_q       <= ST_IDLE;
         digits_q.tens <= START_T;
         digits_q.ones <= START_O;
         running_q     <= 1'b0;
         expired_q     <= 1'b0;
         time_up_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         digits_q  <= digits_d;
         running_q <= running_d;
         expired_q <= expired_d;
         time_up_q <= time_up_d;
      end
   end

   assign OnesValue = digits_q.ones;
   assign TensValue = digits_q.tens;
   assign Running   = running_q;
   assign Expired   = expired_q;
   assign TimeUp    = time_up_q;

endmodule

// File: tb/tb_game_timer.sv
// Scoreboard bench for game_timer: a 60-second unit and a zero-start unit, both at 4 cycles/second.
module tb_game_timer;

   logic clk = 1'b0;
   logic rst, start0, pause0, start1, pause1;
   logic [3:0] ones0, tens0, ones1, tens1;
   logic run0, exp0, tu0, run1, exp1, tu1;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;

   typedef struct {
      int          c;
      int          d;
      logic [10:0] v;
      string       nm;
   } item_t;

   item_t sb[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   game_timer #(.CLOCK_FREQUENCY(4), .START_TENS(6), .START_ONES(0)) dut0 (
      .ClockIn(clk), .Reset(rst), .Start(start0), .Pause(pause0),
      .OnesValue(ones0), .TensValue(tens0), .Running(run0), .Expired(exp0), .TimeUp(tu0)
   );

   game_timer #(.CLOCK_FREQUENCY(4), .START_TENS(0), .START_ONES(0)) dut1 (
      .ClockIn(clk), .Reset(rst), .Start(start1), .Pause(pause1),
      .OnesValue(ones1), .TensValue(tens1), .Running(run1), .Expired(exp1), .TimeUp(tu1)
   );

   task automatic push(input int c, input int d, input logic [3:0] t, input logic [3:0] o,
                       input logic r, input logic e, input logic tu, input string nm);
      item_t it;
      it.c  = c;
      it.d  = d;
      it.v  = {t, o, r, e, tu};
      it.nm = nm;
      sb.push_back(it);
   endtask

   task automatic step_to(input int target);
      while (cyc < target) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Monitor: compare every expectation due by this cycle against the settled outputs.
   always @(negedge clk) begin
      logic [10:0] got;
      item_t it;
      while (sb.size() > 0 && sb[0].c <= cyc) begin
         it  = sb.pop_front();
         got = (it.d == 0) ? {tens0, ones0, run0, exp0, tu0} : {tens1, ones1, run1, exp1, tu1};
         total++;
         if (it.c != cyc || got !== it.v) begin
            bad++;
            $display("FAIL %s dut%0d cyc=%0d due=%0d got{T,O,R,E,U}=%h want=%h",
                     it.nm, it.d, cyc, it.c, got, it.v);
         end
      end
   end

   initial begin
      #60000;
      $display("FAIL watchdog cyc=%0d pending=%0d", cyc, sb.size());
      $fatal(1);
   end

   initial begin
      int s, e, r;
      rst = 1'b1; start0 = 1'b0; pause0 = 1'b0; start1 = 1'b0; pause1 = 1'b0;
      step_to(1);
      push(2, 0, 4'd6, 4'd0, 1'b0, 1'b0, 1'b0, "reset0");
      push(2, 1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, "reset1");
      step_to(2);
      rst = 1'b0; pause0 = 1'b1; start1 = 1'b1;
      push(3, 0, 4'd6, 4'd0, 1'b0, 1'b0, 1'b0, "idle_pause_ignored");
      push(3, 1, 4'd0, 4'd0, 1'b0, 1'b1, 1'b1, "zero_start_timeup");
      step_to(3);
      start0 = 1'b1; start1 = 1'b0;
      push(4, 0, 4'd6, 4'd0, 1'b1, 1'b0, 1'b0, "start_with_pause");
      push(4, 1, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, "zero_start_expired");
      step_to(4);
      s = cyc;
      start0 = 1'b0; pause0 = 1'b0;
      push(s + 3,   0, 4'd6, 4'd0, 1'b1, 1'b0, 1'b0, "pre_first_tick");
      push(s + 4,   0, 4'd5, 4'd9, 1'b1, 1'b0, 1'b0, "first_tick_59");
      push(s + 43,  0, 4'd5, 4'd0, 1'b1, 1'b0, 1'b0, "at_50");
      push(s + 44,  0, 4'd4, 4'd9, 1'b1, 1'b0, 1'b0, "tens_borrow");
      push(s + 239, 0, 4'd0, 4'd1, 1'b1, 1'b0, 1'b0, "at_01");
      push(s + 240, 0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b1, "timeup_at_240");
      push(s + 241, 0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, "timeup_one_cycle");
      push(s + 245, 0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, "expired_pause_ignored");
      // Start mid-run must not disturb tick timing (checked by the later entries).
      step_to(s + 49); start0 = 1'b1;
      step_to(s + 50); start0 = 1'b0;
      step_to(s + 241); pause0 = 1'b1;
      step_to(s + 245); pause0 = 1'b0; start0 = 1'b1;
      e = cyc;
      r = e + 1;
      push(r,       0, 4'd6, 4'd0, 1'b1, 1'b0, 1'b0, "restart_from_expired");
      push(r + 62,  0, 4'd4, 4'd5, 1'b0, 1'b0, 1'b0, "paused_at_45");
      push(r + 71,  0, 4'd4, 4'd5, 1'b0, 1'b0, 1'b0, "paused_held");
      push(r + 72,  0, 4'd4, 4'd5, 1'b1, 1'b0, 1'b0, "resumed");
      push(r + 74,  0, 4'd4, 4'd5, 1'b1, 1'b0, 1'b0, "resume_no_reload");
      push(r + 75,  0, 4'd4, 4'd4, 1'b1, 1'b0, 1'b0, "resume_tick_44");
      push(r + 79,  0, 4'd4, 4'd4, 1'b0, 1'b0, 1'b0, "pause_beats_tick");
      push(r + 83,  0, 4'd4, 4'd4, 1'b1, 1'b0, 1'b0, "resumed_at_zero");
      push(r + 84,  0, 4'd4, 4'd3, 1'b1, 1'b0, 1'b0, "tick_first_resumed");
      push(r + 165, 0, 4'd2, 4'd3, 1'b1, 1'b0, 1'b0, "at_23");
      push(r + 166, 0, 4'd6, 4'd0, 1'b0, 1'b0, 1'b0, "reset_midrun");
      push(r + 170, 0, 4'd6, 4'd0, 1'b0, 1'b0, 1'b0, "idle_after_reset");
      push(r + 171, 0, 4'd6, 4'd0, 1'b1, 1'b0, 1'b0, "start_after_reset");
      push(r + 174, 0, 4'd6, 4'd0, 1'b1, 1'b0, 1'b0, "prescaler_reset_pre");
      push(r + 175, 0, 4'd5, 4'd9, 1'b1, 1'b0, 1'b0, "prescaler_reset_tick");
      step_to(r);       start0 = 1'b0;
      step_to(r + 61);  pause0 = 1'b1;
      step_to(r + 71);  pause0 = 1'b0;
      step_to(r + 78);  pause0 = 1'b1;
      step_to(r + 82);  pause0 = 1'b0;
      step_to(r + 165); rst = 1'b1;
      step_to(r + 166); rst = 1'b0;
      step_to(r + 170); start0 = 1'b1;
      step_to(r + 171); start0 = 1'b0;
      step_to(r + 178);
      total++;
      if (tens0 !== 4'd5 || ones0 !== 4'd9) begin
         bad++;
         $display("FAIL final_digits0 got=%0d%0d want=59", tens0, ones0);
      end
      total++;
      if (run0 !== 1'b1 || exp0 !== 1'b0 || tu0 !== 1'b0) begin
         bad++;
         $display("FAIL final_flags0 R=%b E=%b U=%b", run0, exp0, tu0);
      end
      total++;
      if (tens1 !== 4'd0 || ones1 !== 4'd0) begin
         bad++;
         $display("FAIL final_digits1 got=%0d%0d want=00", tens1, ones1);
      end
      total++;
      if (run1 !== 1'b0 || exp1 !== 1'b0 || tu1 !== 1'b0) begin
         bad++;
         $display("FAIL final_flags1 R=%b E=%b U=%b", run1, exp1, tu1);
      end
      while (sb.size() > 0) begin
         item_t it;
         it = sb.pop_front();
         total++;
         bad++;
         $display("FAIL %s never checked due=%0d want=%h", it.nm, it.c, it.v);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
